// File: rtl/serial_adder.sv
// Bit-serial adder: forms sum = a + b one bit per clock, LSB first, framed by
// a start/busy/done handshake. The result stays registered until the next op completes.
module serial_adder #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  // Holds partial-sum bits [WIDTH-1:1]; bit 0 always falls off before the result is taken
  logic [WIDTH-2:0] r_rs;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_rs_full;

  function automatic logic majority(input logic x, input logic y, input logic z);
    majority = (x & y) | (x & z) | (y & z);
  endfunction

  assign w_s       = r_ra[0] ^ r_rb[0] ^ r_c;
  assign w_carry   = majority(r_ra[0], r_rb[0], r_c);
  assign w_last    = (r_cnt == LAST_BIT);
  assign w_rs_full = {w_s, r_rs};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, bit-serial add, result load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_rs   <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ra  <= a;
            r_rb  <= b;
            r_rs  <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
          r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
          r_rs  <= w_rs_full[WIDTH-1:1];
          r_c   <= w_carry;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_rs_full;
            r_cout <= w_carry;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode straight from registered state, so nothing combinational reaches them from inputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=3.
module tb_serial_adder;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observes n negedges (the current one counts as k=0, the first after the accept edge).
  task automatic watch(input int n, output int done_at, output int ndone, output int busy_cyc);
    done_at  = -1;
    ndone    = 0;
    busy_cyc = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  // Presents operands with start for one edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a     = 3'd5;
    b     = 3'd1;
    @(negedge clk);
    checks++;
    if ({busy, done, cout, sum} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b cout=%b sum=%0d required all 0", busy, done, cout, sum);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, cout, sum} !== 6'b0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: busy=%b done=%b cout=%b sum=%0d required all 0",
                 i, busy, done, cout, sum);
      end
    end
  endtask

  task automatic test_basic();
    int done_at, ndone, busy_cyc;
    issue(3'd5, 3'd2);
    watch(10, done_at, ndone, busy_cyc);
    checks++;
    if (done_at !== 3) begin
      errors++;
      $display("FAIL basic_latency: done at %0d edges after accept, required 3", done_at);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL basic_done_count: %0d pulses, required 1", ndone);
    end
    checks++;
    if (busy_cyc !== 4) begin
      errors++;
      $display("FAIL basic_busy_cycles: %0d, required 4", busy_cyc);
    end
    checks++;
    if (sum !== 3'd7 || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%0d cout=%b, required sum=7 cout=0", sum, cout);
    end
  endtask

  task automatic test_overflow();
    int done_at, ndone, busy_cyc;
    issue(3'd7, 3'd1);
    watch(8, done_at, ndone, busy_cyc);
    checks++;
    if (ndone !== 1 || sum !== 3'd0 || cout !== 1'b1) begin
      errors++;
      $display("FAIL ovf_7p1: done=%0d sum=%0d cout=%b, required done=1 sum=0 cout=1", ndone, sum, cout);
    end
    issue(3'd7, 3'd7);
    done_at = -1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (done && done_at < 0) done_at = k;
      if (done_at < 0) begin
        checks++;
        if (sum !== 3'd0 || cout !== 1'b1) begin
          errors++;
          $display("FAIL ovf_hold[%0d]: sum=%0d cout=%b, required sum=0 cout=1", k, sum, cout);
        end
      end
    end
    checks++;
    if (done_at !== 3 || sum !== 3'd6 || cout !== 1'b1) begin
      errors++;
      $display("FAIL ovf_7p7: done_at=%0d sum=%0d cout=%b, required done_at=3 sum=6 cout=1",
               done_at, sum, cout);
    end
  endtask

  task automatic test_ignored_start();
    int ndone;
    issue(3'd3, 3'd3);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (done) ndone++;
      start = 1'b0;
      if (k == 0 || k == 3) begin
        a     = 3'd1;
        b     = 3'd1;
        start = 1'b1;
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignored_start_done_count: %0d pulses, required 1", ndone);
    end
    checks++;
    if (sum !== 3'd6 || cout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start_result: sum=%0d cout=%b busy=%b, required sum=6 cout=0 busy=0",
               sum, cout, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    int done_at, ndone, busy_cyc;
    issue(3'd6, 3'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, cout, sum} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%b done=%b cout=%b sum=%0d required all 0", busy, done, cout, sum);
    end
    watch(8, done_at, ndone, busy_cyc);
    checks++;
    if (ndone !== 0 || busy_cyc !== 0) begin
      errors++;
      $display("FAIL mid_reset_abort: done=%0d busy_cycles=%0d, required 0 and 0", ndone, busy_cyc);
    end
    issue(3'd2, 3'd2);
    watch(8, done_at, ndone, busy_cyc);
    checks++;
    if (done_at !== 3 || ndone !== 1 || sum !== 3'd4 || cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_recover: done_at=%0d done=%0d sum=%0d cout=%b, required 3 1 4 0",
               done_at, ndone, sum, cout);
    end
  endtask

  task automatic test_back_to_back();
    int issue_idx, res_idx, cyc, last_done;
    int x, y;
    issue_idx = 0;
    res_idx   = 0;
    cyc       = 0;
    last_done = -1;
    while (res_idx < 64 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        x = res_idx / 8;
        y = res_idx % 8;
        checks++;
        if (sum !== 3'(x)) begin
          errors++;
          $display("FAIL roundtrip_sum x=%0d y=%0d: sum=%0d required %0d", x, y, sum, x);
        end
        checks++;
        if (cout !== (x < y)) begin
          errors++;
          $display("FAIL roundtrip_cout x=%0d y=%0d: cout=%b required %b", x, y, cout, (x < y));
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== 5) begin
            errors++;
            $display("FAIL b2b_period op %0d: %0d cycles, required 5", res_idx, cyc - last_done);
          end
        end
        last_done = cyc;
        res_idx++;
      end
      if (!busy) begin
        if (issue_idx < 64) begin
          x     = issue_idx / 8;
          y     = issue_idx % 8;
          a     = 3'(x - y);
          b     = 3'(y);
          start = 1'b1;
          issue_idx++;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (res_idx !== 64) begin
      errors++;
      $display("FAIL b2b_timeout: %0d results, required 64", res_idx);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
